distribuidor_filtros: RTL and testbench

DISTRIBUIDOR_FILTROS -- requirements
Module: distribuidor_filtros

---
 rtl/distribuidor_filtros_pkg.sv | 28 ++
 rtl/distribuidor_filtros_temporizador_ack.sv | 27 ++
 rtl/distribuidor_filtros.sv | 139 +++++++++++++
 tb/tb_distribuidor_filtros.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/distribuidor_filtros_pkg.sv
// Shared encodings for the filter-bank sample distributor.
package distribuidor_filtros_pkg;

    localparam int N_DEF    = 23;
    localparam int TMAX_DEF = 255;

    localparam logic [1:0] CASO_BAJOS  = 2'b00;
    localparam logic [1:0] CASO_MEDIOS = 2'b01;
    localparam logic [1:0] CASO_ALTOS  = 2'b10;
    localparam logic [1:0] CASO_IDLE   = 2'b11;

    // State codes equal the caso codes, so caso is the state register itself.
    typedef enum logic [1:0] {
        ENV_B = CASO_BAJOS,
        ENV_M = CASO_MEDIOS,
        ENV_A = CASO_ALTOS,
        IDLE  = CASO_IDLE
    } estado_t;

    // First enabled channel in dispatch order B, M, A; IDLE when none is left.
    function automatic estado_t primer_canal(input logic [2:0] m);
        if (m[0]) return ENV_B;
        if (m[1]) return ENV_M;
        if (m[2]) return ENV_A;
        return IDLE;
    endfunction

endpackage

// File: rtl/distribuidor_filtros_temporizador_ack.sv
// Per-channel ack wait counter: restarts on load, stops at TMAX-1 and flags it.
module temporizador_ack #(
    parameter int TMAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cargar,
    output logic o_tc
);

    localparam logic [7:0] TC = 8'(TMAX - 1);

    logic [7:0] r_cnt;

    // Count cycles spent in the current channel; hold at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= 8'd0;
        else if (i_cargar)
            r_cnt <= 8'd0;
        else if (r_cnt != TC)
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/distribuidor_filtros.sv
// Distributes each accepted sample to the enabled filter channels, one at a time.
module distribuidor_filtros
    import distribuidor_filtros_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int TMAX = TMAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [N-1:0] dato_in,
    input  logic                dato_valid,
    output logic                listo,
    input  logic [2:0]          mascara,
    output logic signed [N-1:0] bajos,
    output logic signed [N-1:0] medios,
    output logic signed [N-1:0] altos,
    output logic                val_b,
    output logic                val_m,
    output logic                val_a,
    input  logic                ack_b,
    input  logic                ack_m,
    input  logic                ack_a,
    output logic [1:0]          caso,
    output logic                fin,
    input  logic                clr,
    output logic                error,
    output logic [7:0]          perdidos
);

    estado_t             r_estado, w_estado_sig;
    logic signed [N-1:0] r_dato, r_bajos, r_medios, r_altos;
    logic signed [N-1:0] w_dato_env;
    logic [2:0]          r_mascara;
    logic                r_fin, w_fin_sig;
    logic                r_error, w_timeout;
    logic [7:0]          r_perdidos;
    logic                w_tc, w_cargar, w_acepta, w_pierde;

    assign w_acepta = (r_estado == IDLE) && dato_valid;
    assign w_pierde = (r_estado != IDLE) && dato_valid;

    // Next state: leave a channel on transfer or on ack timeout.
    always_comb begin
        w_estado_sig = r_estado;
        w_timeout    = 1'b0;
        case (r_estado)
            IDLE:  if (dato_valid) w_estado_sig = primer_canal(mascara);
            ENV_B: if (ack_b || w_tc) begin
                       w_estado_sig = primer_canal(r_mascara & 3'b110);
                       w_timeout    = !ack_b;
                   end
            ENV_M: if (ack_m || w_tc) begin
                       w_estado_sig = primer_canal(r_mascara & 3'b100);
                       w_timeout    = !ack_m;
                   end
            ENV_A: if (ack_a || w_tc) begin
                       w_estado_sig = IDLE;
                       w_timeout    = !ack_a;
                   end
            default: w_estado_sig = IDLE;
        endcase
    end

    // fin covers both a finished dispatch and an accept with an empty mask.
    assign w_fin_sig  = (w_estado_sig == IDLE) && ((r_estado != IDLE) || dato_valid);
    // First channel loads straight from the input; later ones from the latch.
    assign w_dato_env = (r_estado == IDLE) ? dato_in : r_dato;
    assign w_cargar   = (r_estado == IDLE) || (w_estado_sig != r_estado);

    temporizador_ack #(.TMAX(TMAX)) u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .i_cargar (w_cargar),
        .o_tc     (w_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_estado <= IDLE;
        else       r_estado <= w_estado_sig;
    end

    // Latch sample and mask at accept for the later channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dato    <= '0;
            r_mascara <= 3'b000;
        end else if (w_acepta) begin
            r_dato    <= dato_in;
            r_mascara <= mascara;
        end
    end

    // Channel registers load only when their channel is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bajos  <= '0;
            r_medios <= '0;
            r_altos  <= '0;
        end else begin
            if (w_estado_sig == ENV_B && r_estado != ENV_B) r_bajos  <= w_dato_env;
            if (w_estado_sig == ENV_M && r_estado != ENV_M) r_medios <= w_dato_env;
            if (w_estado_sig == ENV_A && r_estado != ENV_A) r_altos  <= w_dato_env;
        end
    end

    // Completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_fin <= 1'b0;
        else       r_fin <= w_fin_sig;
    end

    // Sticky timeout flag and saturating drop count; clr has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error    <= 1'b0;
            r_perdidos <= 8'd0;
        end else if (clr) begin
            r_error    <= 1'b0;
            r_perdidos <= 8'd0;
        end else begin
            if (w_timeout) r_error <= 1'b1;
            if (w_pierde && r_perdidos != 8'hFF) r_perdidos <= r_perdidos + 8'd1;
        end
    end

    assign listo    = (r_estado == IDLE);
    assign caso     = r_estado;
    assign val_b    = (r_estado == ENV_B);
    assign val_m    = (r_estado == ENV_M);
    assign val_a    = (r_estado == ENV_A);
    assign bajos    = r_bajos;
    assign medios   = r_medios;
    assign altos    = r_altos;
    assign fin      = r_fin;
    assign error    = r_error;
    assign perdidos = r_perdidos;

endmodule

// File: tb/tb_distribuidor_filtros.sv
// Scoreboard bench: driver queues expected channel deliveries, monitor checks them.
module tb_distribuidor_filtros;

    localparam int N    = 23;
    localparam int TMAX = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [N-1:0] dato_in = '0;
    logic                dato_valid = 1'b0;
    logic                listo;
    logic [2:0]          mascara = 3'b000;
    logic signed [N-1:0] bajos, medios, altos;
    logic                val_b, val_m, val_a;
    logic                ack_b = 1'b0, ack_m = 1'b0, ack_a = 1'b0;
    logic [1:0]          caso;
    logic                fin;
    logic                clr = 1'b0;
    logic                error;
    logic [7:0]          perdidos;

    distribuidor_filtros #(.N(N), .TMAX(TMAX)) dut (
        .clk(clk), .reset(reset), .dato_in(dato_in), .dato_valid(dato_valid),
        .listo(listo), .mascara(mascara), .bajos(bajos), .medios(medios),
        .altos(altos), .val_b(val_b), .val_m(val_m), .val_a(val_a),
        .ack_b(ack_b), .ack_m(ack_m), .ack_a(ack_a), .caso(caso), .fin(fin),
        .clr(clr), .error(error), .perdidos(perdidos)
    );

    always #5 clk = ~clk;

    // Expected delivery: ch 0/1/2 = bajos/medios/altos, ch 3 = end of sample.
    typedef struct { int ch; int d; } ent_t;
    ent_t q[$];

    // Reference model of the visible behaviour, one cycle at a time.
    bit m_idle = 1'b1;
    bit m_fin  = 1'b0;
    bit m_err  = 1'b0;
    int m_perd = 0;
    int wcnt   = 0;
    int m_reg[3] = '{0, 0, 0};

    int vectors = 0, miscompares = 0;

    // Stimulus knobs.
    int          shots = 0, valid_prob = 100, clr_prob = 0, fd = 0;
    bit          hold_valid = 1'b0, fd_en = 1'b0, fm_en = 1'b0;
    logic [2:0]  fm = 3'b000;
    int          ack_p[3] = '{100, 100, 100};

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Driver: new inputs shortly after each rising edge; queue what an accept must produce.
    always @(posedge clk) begin
        #1;
        ack_b   = (int'($urandom_range(99)) < ack_p[0]);
        ack_m   = (int'($urandom_range(99)) < ack_p[1]);
        ack_a   = (int'($urandom_range(99)) < ack_p[2]);
        clr     = (int'($urandom_range(99)) < clr_prob);
        dato_in = fd_en ? N'(fd) : N'($urandom);
        mascara = fm_en ? fm : 3'($urandom);
        if (reset) dato_valid = 1'b0;
        else dato_valid = hold_valid || (shots > 0 && int'($urandom_range(99)) < valid_prob);
        if (dato_valid && m_idle) begin
            if (shots > 0) shots--;
            for (int c = 0; c < 3; c++)
                if (mascara[c]) q.push_back('{c, int'(dato_in)});
            q.push_back('{3, 0});
        end
    end

    // Monitor: compare this cycle's outputs, then step the model through the coming edge.
    always @(negedge clk) begin
        int ch;
        bit a;
        bit nf;
        if (reset) begin
            chk("rst_listo",    int'(listo), 1);
            chk("rst_caso",     int'(caso), 3);
            chk("rst_val",      int'({val_a, val_m, val_b}), 0);
            chk("rst_fin",      int'(fin), 0);
            chk("rst_error",    int'(error), 0);
            chk("rst_perdidos", int'(perdidos), 0);
            chk("rst_bajos",    int'(bajos), 0);
            chk("rst_medios",   int'(medios), 0);
            chk("rst_altos",    int'(altos), 0);
            q.delete();
            m_idle = 1'b1; m_fin = 1'b0; m_err = 1'b0; m_perd = 0; wcnt = 0;
            m_reg = '{0, 0, 0};
        end else begin
            ch = (m_idle || q.size() == 0) ? 3 : q[0].ch;
            chk("listo",    int'(listo), int'(m_idle));
            chk("caso",     int'(caso), ch);
            chk("val_b",    int'(val_b), int'(ch == 0));
            chk("val_m",    int'(val_m), int'(ch == 1));
            chk("val_a",    int'(val_a), int'(ch == 2));
            chk("fin",      int'(fin), int'(m_fin));
            chk("error",    int'(error), int'(m_err));
            chk("perdidos", int'(perdidos), m_perd);
            chk("bajos",    int'(bajos), m_reg[0]);
            chk("medios",   int'(medios), m_reg[1]);
            chk("altos",    int'(altos), m_reg[2]);
            nf = 1'b0;
            if (m_idle) begin
                if (dato_valid && q.size() > 0) begin
                    if (q[0].ch == 3) begin
                        void'(q.pop_front());
                        nf = 1'b1;
                    end else begin
                        m_idle = 1'b0;
                        m_reg[q[0].ch] = q[0].d;
                        wcnt = 0;
                    end
                end
            end else begin
                if (dato_valid && m_perd < 255) m_perd++;
                a = (ch == 0) ? ack_b : (ch == 1) ? ack_m : ack_a;
                if (a || wcnt == TMAX - 1) begin
                    if (!a) m_err = 1'b1;
                    void'(q.pop_front());
                    if (q.size() > 0 && q[0].ch != 3) begin
                        m_reg[q[0].ch] = q[0].d;
                        wcnt = 0;
                    end else begin
                        if (q.size() > 0) void'(q.pop_front());
                        m_idle = 1'b1;
                        nf = 1'b1;
                    end
                end else begin
                    wcnt++;
                end
            end
            if (clr) begin
                m_err  = 1'b0;
                m_perd = 0;
            end
            m_fin = nf;
        end
    end

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        @(posedge clk); #3;
        while (!(shots == 0 && !hold_valid && m_idle && q.size() == 0)) begin
            @(posedge clk); #3;
            n++;
            if (n > budget) begin
                vectors++; miscompares++;
                $display("FAIL %s: dispatch still busy after %0d cycles", nm, budget);
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        clr_prob = 100;
        @(posedge clk); #2;
        clr_prob = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Three channels with acks tied high.
        fd_en = 1; fd = -5; fm_en = 1; fm = 3'b111;
        shots = 1;
        wait_idle("seq111", 50);

        // Bajos and altos only, altos ack held back 3 cycles.
        fd = 4194303; fm = 3'b101; ack_p = '{100, 100, 0};
        shots = 1;
        n = 0;
        while (!(!m_idle && q.size() > 0 && q[0].ch == 2) && n < 50) begin
            @(posedge clk); n++;
        end
        chk("reach_altos", int'(n < 50), 1);
        repeat (3) @(posedge clk);
        ack_p[2] = 100;
        wait_idle("seq101", 50);
        chk("no_error_101", int'(error), 0);

        // medios never acked: timeout, altos still delivered, then clear.
        fd_en = 0; fm = 3'b111; ack_p = '{100, 0, 100};
        shots = 1;
        wait_idle("timeout", 50);
        chk("error_set", int'(error), 1);
        pulse_clr();
        @(posedge clk); #3;
        chk("error_clr", int'(error), 0);

        // Held offers during stalled dispatches saturate the drop count.
        ack_p = '{0, 0, 0}; hold_valid = 1;
        repeat (300) @(posedge clk);
        #3;
        chk("perdidos_sat", int'(perdidos), 255);
        n = 0;
        while (!(!m_idle && q.size() >= 2 && q[0].ch != 2) && n < 50) begin
            @(posedge clk); #3; n++;
        end
        pulse_clr();
        hold_valid = 0;
        @(posedge clk); #3;
        chk("perdidos_clr", int'(perdidos), 0);
        ack_p = '{100, 100, 100};
        wait_idle("drain_stall", 50);

        // Reset while medios is being offered.
        fd_en = 1; fd = 12345; fm = 3'b010; ack_p = '{100, 0, 100};
        shots = 1;
        n = 0;
        while (m_idle && n < 50) begin
            @(posedge clk); n++;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        ack_p = '{100, 100, 100};
        fd = -77; fm = 3'b111;
        shots = 1;
        wait_idle("after_reset", 50);

        // Empty mask: fin only.
        fd = 999; fm = 3'b000;
        shots = 1;
        wait_idle("mask000", 20);

        // Random traffic with occasional timeouts, drops and clears.
        fd_en = 0; fm_en = 0; ack_p = '{70, 70, 70};
        valid_prob = 60; clr_prob = 3;
        shots = 150;
        wait_idle("random", 20000);
        clr_prob = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
